// File: rtl/alu_issuer_pkg.sv
// Shared types and constants for the ALU command issuer.
// Holds the FSM state enum, the multiply command codes, the request bundle and flag indices.
package alu_issuer_pkg;

    localparam int REQ_DW = 8;
    localparam int REQ_CW = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] CMD_MUL_INC = 4'd9;
    localparam logic [3:0] CMD_MUL_SHL = 4'd10;

    // Bit positions inside rsp_flags = {COUT,OFLOW,G,E,L,ERR}
    localparam int FLG_ERR   = 0;
    localparam int FLG_L     = 1;
    localparam int FLG_E     = 2;
    localparam int FLG_G     = 3;
    localparam int FLG_OFLOW = 4;
    localparam int FLG_COUT  = 5;

    typedef struct packed {
        logic [REQ_DW-1:0] opa;
        logic [REQ_DW-1:0] opb;
        logic              cin;
        logic [REQ_CW-1:0] cmd;
        logic              mode;
        logic [1:0]        inp_valid;
    } req_t;

    // Multiplies only exist in arithmetic mode
    function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
        return mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL);
    endfunction

endpackage

// File: rtl/alu_issuer_fifo.sv
// Synchronous request FIFO of req_t entries for the ALU command issuer.
// Ports: CLK, RST (sync active-low), push/din, pop/dout (head, show-ahead), full, empty.
module alu_issuer_fifo
    import alu_issuer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic push,
    input  req_t din,
    input  logic pop,
    output req_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    req_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are power-of-two wide, so they wrap on their own
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU requests, issues them one at a time with per-command latency, returns results.
// Ports: CLK/RST (sync active-low), req_* in, ALU pins out, RES+flags in, rsp_* out, busy.
// Build option ALU_ISSUER_TAG_EN adds rsp_tag, an 8-bit issue sequence number.
module alu_cmd_issuer
    import alu_issuer_pkg::*;
#(
    parameter int DW      = REQ_DW,
    parameter int CW      = REQ_CW,
    parameter int DEPTH   = 4,
    parameter int LAT     = 1,
    parameter int MUL_LAT = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [DW-1:0]   req_opa,
    input  logic [DW-1:0]   req_opb,
    input  logic            req_cin,
    input  logic [CW-1:0]   req_cmd,
    input  logic            req_mode,
    input  logic [1:0]      req_inp_valid,
    output logic [DW-1:0]   OPA,
    output logic [DW-1:0]   OPB,
    output logic            CIN,
    output logic [CW-1:0]   CMD,
    output logic            MODE,
    output logic            CE,
    output logic [1:0]      INP_VALID,
    input  logic [2*DW-1:0] RES,
    input  logic            COUT,
    input  logic            OFLOW,
    input  logic            G,
    input  logic            E,
    input  logic            L,
    input  logic            ERR,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*DW-1:0] rsp_res,
    output logic [5:0]      rsp_flags,
`ifdef ALU_ISSUER_TAG_EN
    output logic [7:0]      rsp_tag,
`endif
    output logic            busy
);

    localparam int LMAX = (LAT > MUL_LAT) ? LAT : MUL_LAT;
    localparam int CNTW = (LMAX < 2) ? 1 : $clog2(LMAX + 1);

    state_t          state;
    state_t          state_nx;
    logic            issue;
    logic            capture;
    logic            rel;
    logic            push;
    logic            fifo_full;
    logic            fifo_empty;
    req_t            req_in;
    req_t            head;
    logic [CNTW-1:0] cnt;
    logic [5:0]      flags_in;

    assign req_in = '{
        opa:       req_opa,
        opb:       req_opb,
        cin:       req_cin,
        cmd:       req_cmd,
        mode:      req_mode,
        inp_valid: req_inp_valid
    };

    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    alu_issuer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .din   (req_in),
        .pop   (issue),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        flags_in            = '0;
        flags_in[FLG_COUT]  = COUT;
        flags_in[FLG_OFLOW] = OFLOW;
        flags_in[FLG_G]     = G;
        flags_in[FLG_E]     = E;
        flags_in[FLG_L]     = L;
        flags_in[FLG_ERR]   = ERR;
    end

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        capture  = 1'b0;
        rel      = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                if (!fifo_empty) begin
                    issue    = 1'b1;
                    state_nx = WAIT;
                end
            end
            (state == WAIT): begin
                if (cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            (state == RESP): begin
                if (rsp_ready) begin
                    rel = 1'b1;
                    // Back-to-back issue avoids an IDLE bubble
                    if (!fifo_empty) begin
                        issue    = 1'b1;
                        state_nx = WAIT;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            OPA       <= '0;
            OPB       <= '0;
            CIN       <= 1'b0;
            CMD       <= '0;
            MODE      <= 1'b0;
            CE        <= 1'b0;
            INP_VALID <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_flags <= '0;
        end else begin
            if (issue) begin
                OPA       <= head.opa;
                OPB       <= head.opb;
                CIN       <= head.cin;
                CMD       <= head.cmd;
                MODE      <= head.mode;
                INP_VALID <= head.inp_valid;
                CE        <= 1'b1;
                cnt       <= is_mul(head.mode, head.cmd)
                           ? CNTW'(MUL_LAT) : CNTW'(LAT);
            end else if (rel) begin
                OPA       <= '0;
                OPB       <= '0;
                CIN       <= 1'b0;
                CMD       <= '0;
                MODE      <= 1'b0;
                CE        <= 1'b0;
                INP_VALID <= '0;
            end else if (capture) begin
                CE        <= 1'b0;
                INP_VALID <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end

            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_res   <= RES;
                rsp_flags <= flags_in;
            end else if (rel) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUER_TAG_EN
    logic [7:0] tag_cnt;
    logic [7:0] tag_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            tag_cnt <= '0;
            tag_q   <= '0;
            rsp_tag <= '0;
        end else begin
            if (issue) begin
                tag_q   <= tag_cnt;
                tag_cnt <= tag_cnt + 8'd1;
            end
            if (capture) rsp_tag <= tag_q;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a small pipelined ALU stand-in.
// Directed vectors push expected results; a negedge monitor pops and compares.
module tb_alu_cmd_issuer;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_opa;
    logic [7:0]  req_opb;
    logic        req_cin;
    logic [3:0]  req_cmd;
    logic        req_mode;
    logic [1:0]  req_inp_valid;
    logic [7:0]  OPA;
    logic [7:0]  OPB;
    logic        CIN;
    logic [3:0]  CMD;
    logic        MODE;
    logic        CE;
    logic [1:0]  INP_VALID;
    logic [15:0] RES;
    logic        COUT, OFLOW, G, E, L, ERR;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_res;
    logic [5:0]  rsp_flags;
    logic        busy;
`ifdef ALU_ISSUER_TAG_EN
    logic [7:0]  rsp_tag;
`endif

    alu_cmd_issuer dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opa       (req_opa),
        .req_opb       (req_opb),
        .req_cin       (req_cin),
        .req_cmd       (req_cmd),
        .req_mode      (req_mode),
        .req_inp_valid (req_inp_valid),
        .OPA           (OPA),
        .OPB           (OPB),
        .CIN           (CIN),
        .CMD           (CMD),
        .MODE          (MODE),
        .CE            (CE),
        .INP_VALID     (INP_VALID),
        .RES           (RES),
        .COUT          (COUT),
        .OFLOW         (OFLOW),
        .G             (G),
        .E             (E),
        .L             (L),
        .ERR           (ERR),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_res       (rsp_res),
        .rsp_flags     (rsp_flags),
`ifdef ALU_ISSUER_TAG_EN
        .rsp_tag       (rsp_tag),
`endif
        .busy          (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ALU stand-in: one register stage for normal ops, two for multiplies
    function automatic logic [21:0] alu_f(
        input logic [7:0] a, input logic [7:0] b, input logic ci,
        input logic [3:0] c, input logic m, input logic [1:0] iv);
        logic [15:0] r;
        logic [5:0]  f;
        r = '0;
        f = '0;
        if (iv != 2'b11) f[0] = 1'b1;
        else if (m) begin
            case (c)
                4'd0: begin
                    r = {8'h0, a} + {8'h0, b} + {15'h0, ci};
                    f[5] = r[8];
                end
                4'd1: begin
                    r = {8'h0, a - b};
                    f[4] = (a < b);
                end
                4'd9:  r = ({8'h0, a} + 16'd1) * ({8'h0, b} + 16'd1);
                4'd10: r = ({8'h0, a} << 1) * {8'h0, b};
                default: f[0] = 1'b1;
            endcase
        end else begin
            case (c)
                4'd0: r = {8'h0, a & b};
                4'd1: r = {8'h0, a | b};
                4'd2: r = {8'h0, a ^ b};
                default: f[0] = 1'b1;
            endcase
        end
        return {r, f};
    endfunction

    logic [21:0] s1, s2, sel;
    always @(posedge CLK) begin
        if (CE) s1 <= alu_f(OPA, OPB, CIN, CMD, MODE, INP_VALID);
        s2 <= s1;
    end
    assign sel = (MODE && (CMD == 4'd9 || CMD == 4'd10)) ? s2 : s1;
    assign RES = sel[21:6];
    assign {COUT, OFLOW, G, E, L, ERR} = sel[5:0];

    typedef struct packed {
        logic [15:0] res;
        logic [5:0]  flags;
        logic [7:0]  tag;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] tag_next = 8'd0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, need %0h", name, act, req);
        end
    endtask

    // Monitor: pop on each handshake, and demand stable rsp_* while stalled
    logic [22:0] held;
    bit          stalled = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            if (stalled)
                check("rsp_hold", {rsp_valid, rsp_res, rsp_flags}, held);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected: got res %0h, none pending",
                             rsp_res);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_res", rsp_res, e.res);
                    check("rsp_flags", rsp_flags, e.flags);
`ifdef ALU_ISSUER_TAG_EN
                    check("rsp_tag", rsp_tag, e.tag);
`endif
                end
            end
            stalled = rsp_valid && !rsp_ready;
            held    = {rsp_valid, rsp_res, rsp_flags};
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic m, input logic [3:0] c,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [1:0] iv,
                        input logic [15:0] er, input logic [5:0] ef,
                        input bit want);
        bit acc;
        acc           = 1'b0;
        req_mode      = m;
        req_cmd       = c;
        req_opa       = a;
        req_opb       = b;
        req_cin       = ci;
        req_inp_valid = iv;
        req_valid     = 1'b1;
        for (int n = 0; n < 50; n++) begin
            acc = req_ready;
            tick();
            if (acc) break;
        end
        req_valid = 1'b0;
        if (!acc) check("push_timeout", 0, 1);
        else begin
            if (want) exp_q.push_back('{res: er, flags: ef, tag: tag_next});
            tag_next = tag_next + 8'd1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rsp_valid || exp_q.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        check("drain_done", (n < 2000), 1);
    endtask

    task automatic single(input logic m, input logic [3:0] c,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [1:0] iv,
                          input logic [15:0] er, input logic [5:0] ef,
                          input int lat);
        int ce_cyc;
        push(m, c, a, b, ci, iv, er, ef, 1'b1);
        for (int k = 0; k < 10 && !CE; k++) tick();
        check("opa_pin", OPA, a);
        check("opb_pin", OPB, b);
        ce_cyc = 0;
        while (CE && ce_cyc < 20) begin
            ce_cyc++;
            tick();
        end
        check("ce_cycles", ce_cyc, lat + 1);
        check("rsp_valid_at_ce_fall", rsp_valid, 1);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST           = 1'b0;
        req_valid     = 1'b0;
        req_opa       = '0;
        req_opb       = '0;
        req_cin       = 1'b0;
        req_cmd       = '0;
        req_mode      = 1'b0;
        req_inp_valid = '0;
        rsp_ready     = 1'b1;
        repeat (3) tick();
        RST = 1'b1;
        tick();
        check("reset_alu", {OPA, OPB, CIN, CMD, MODE, CE, INP_VALID}, 0);
        check("reset_rsp", {rsp_valid, rsp_res, rsp_flags, busy}, 0);
        check("reset_req_ready", req_ready, 1);

        // mode, cmd, opa, opb, cin, inp_valid, res, flags, latency
        single(1, 4'd0,  8'h0F, 8'h01, 0, 2'b11, 16'h0010, 6'b000000, 1);
        single(1, 4'd9,  8'd3,  8'd4,  0, 2'b11, 16'd20,   6'b000000, 2);
        single(1, 4'd0,  8'hFF, 8'h01, 0, 2'b11, 16'h0100, 6'b100000, 1);
        single(1, 4'd0,  8'h0F, 8'h01, 1, 2'b11, 16'h0011, 6'b000000, 1);
        single(1, 4'd1,  8'd9,  8'd3,  0, 2'b11, 16'h0006, 6'b000000, 1);
        single(1, 4'd10, 8'd5,  8'd3,  0, 2'b11, 16'd30,   6'b000000, 2);
        single(0, 4'd0,  8'hFF, 8'h0F, 0, 2'b01, 16'h0000, 6'b000001, 1);
        single(0, 4'd1,  8'hF0, 8'h0C, 0, 2'b11, 16'h00FC, 6'b000000, 1);
        single(0, 4'd9,  8'd3,  8'd4,  0, 2'b11, 16'h0000, 6'b000001, 1);

        // Backpressure: one in flight plus DEPTH queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push(1, 4'd0, 8'(i + 1), 8'h10, 0, 2'b11,
                 16'(17 + i), 6'b000000, 1'b1);
        check("req_ready_full", req_ready, 0);
        check("busy_full", busy, 1);
        repeat (4) tick();
        check("stall_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 40);
        check("drain_cycles", n, 13);
        wait_idle();

        // Reset while the first multiply waits, with one more queued
        push(1, 4'd9, 8'd7, 8'd7, 0, 2'b11, 16'd0, 6'd0, 1'b0);
        push(1, 4'd9, 8'd2, 8'd2, 0, 2'b11, 16'd0, 6'd0, 1'b0);
        check("pre_reset_ce", CE, 1);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        tag_next = 8'd0;
        check("mid_reset_ce", CE, 0);
        check("mid_reset_rsp_valid", rsp_valid, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_req_ready", req_ready, 1);
        repeat (8) tick();
        check("mid_reset_no_rsp", rsp_valid, 0);

`ifdef ALU_ISSUER_TAG_EN
        for (int i = 0; i < 257; i++)
            push(1, 4'd0, 8'(i), 8'h00, 0, 2'b11,
                 16'(i % 256), 6'b000000, 1'b1);
        wait_idle();
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Hardware initiator for the ALU operand interface. It drives the same signals our bench driver drives (OPA, OPB, CIN, CMD, MODE, CE, INP_VALID) and collects RES and the flags.
- Upstream logic enqueues ALU requests over a valid/ready port. The block buffers them, issues one operation at a time with the correct per-command latency, and returns each result on a valid/ready response port.
- It sits between any on-chip command source and ALU_DESIGN.

Parameters:
- DW, 8, operand width.
- CW, 4, command width.
- DEPTH, 4, request FIFO entries (power of two, ≥2).
- LAT, 1, ALU result latency in cycles for normal commands.
- MUL_LAT, 2, ALU result latency in cycles for multiply commands (MODE=1, CMD=9 or 10).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request FIFO not full.
- req_opa  in  DW  operand A.
- req_opb  in  DW  operand B.
- req_cin  in  1  carry-in.
- req_cmd  in  CW  ALU command.
- req_mode  in  1  1=arithmetic, 0=logical.
- req_inp_valid  in  2  operand-valid code passed to the ALU.
- OPA  out  DW  ALU operand A.
- OPB  out  DW  ALU operand B.
- CIN  out  1  ALU carry-in.
- CMD  out  CW  ALU command.
- MODE  out  1  ALU mode.
- CE  out  1  ALU clock enable.
- INP_VALID  out  2  ALU operand-valid code.
- RES  in  2*DW  ALU result.
- COUT, OFLOW, G, E, L, ERR  in  1 each  ALU flags.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed.
- rsp_res  out  2*DW  captured RES.
- rsp_flags  out  6  captured flags, ordered {COUT,OFLOW,G,E,L,ERR}.
- busy  out  1  FSM not IDLE, or FIFO not empty.

Behaviour:
- Reset:
  - Sync active-low: RST=0 sampled at a rising CLK edge resets the block.
  - All outputs go to 0, except req_ready=1 once RST=1.
  - FIFO is emptied; FSM goes to IDLE.
- Request acceptance:
  - A request is accepted on an edge where req_valid && req_ready.
  - req_ready = !fifo_full.
  - The FIFO pushes on acceptance and pops on issue. A simultaneous push and pop leaves the count unchanged.
- All ALU-side outputs and response outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- IDLE, FIFO non-empty at edge e0:
  - Pop the head entry.
  - Load OPA/OPB/CIN/CMD/MODE/INP_VALID from the entry; set CE=1.
  - Load cnt = (MODE && (CMD==9 || CMD==10)) ? MUL_LAT : LAT.
  - Go to WAIT.
- IDLE, FIFO empty: ALU outputs hold 0, CE=0.
- WAIT:
  - ALU inputs held stable, CE=1.
  - cnt decrements each edge.
  - On the edge where cnt==0: capture RES and the flags into rsp_res/rsp_flags; set rsp_valid=1, CE=0, INP_VALID=0; go to RESP.
  - Net effect: capture happens on edge e(lat+1); rsp_valid is visible lat+1 cycles after the ALU inputs appear.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On the edge with rsp_ready: clear rsp_valid. Go to IDLE, or issue the next FIFO entry directly on that same edge if the FIFO is non-empty, with no IDLE bubble.
- Requests keep being accepted in every state until the FIFO is full.
- Requests are never reordered or dropped.
- ERR from the ALU is captured as a normal flag; the block does no command legality check.
- Reset mid-operation (WAIT or RESP): the in-flight operation and all queued entries are discarded. No response is emitted.
- FIFO pointers: log2(DEPTH) bits with a separate count. The pointers wrap modulo DEPTH.

Optional Feature:
- Macro: ALU_ISSUER_TAG_EN.
- Defined:
  - Adds output rsp_tag [7:0], and an 8-bit issue counter that resets to 0.
  - The counter increments on each issue and wraps 255→0.
  - The tag value is latched with the request at issue and presented with its response.
- Undefined: no rsp_tag port and no counter; all other behaviour is identical.

Decomposition:
- Package alu_issuer_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - constants CMD_MUL_INC=4'd9 and CMD_MUL_SHL=4'd10;
  - packed struct req_t {opa, opb, cin, cmd, mode, inp_valid};
  - flag index constants.
- Sub-module alu_issuer_fifo (sync FIFO of req_t, DEPTH, push/pop/full/empty) is instantiated once.
- The FSM and response register live in alu_cmd_issuer.

Test Plan:
- Basic add: MODE=1, CMD=0, OPA=8'h0F, OPB=8'h01, INP_VALID=2'b11, rsp_ready=1.
  - Expect OPA/OPB on ALU pins for 2 cycles with CE=1.
  - Expect rsp_valid 2 cycles after issue, rsp_res=16'h0010, rsp_flags=6'b0.
- Multiply: MODE=1, CMD=9, OPA=3, OPB=4.
  - Expect CE high 3 cycles and rsp_valid 3 cycles after issue.
  - Expect rsp_res = (3+1)*(4+1) = 20.
- Backpressure: push 5 requests back-to-back with rsp_ready=0.
  - req_ready drops after FIFO full (DEPTH=4 plus one in flight).
  - rsp_* is stable while stalled.
  - Releasing rsp_ready drains the requests in order with no bubble.
- Logical ERR case: MODE=0, INP_VALID=2'b01 with a two-operand CMD.
  - Expect rsp_flags[0]=ERR=1, passed through unchanged.
- Reset mid-WAIT: assert RST=0 for 1 cycle during WAIT.
  - Next cycle: CE=0, rsp_valid=0, busy=0, FIFO empty; no response emitted.
- With ALU_ISSUER_TAG_EN: issue 257 requests.
  - Tags run 0..255 then 0; response 257 carries rsp_tag=8'h00.
